// File: rtl/particle_plotter.sv
// Snapshots four particle positions on a physics strobe and scans them onto a
// row-multiplexed GRID x GRID LED matrix, promoting new images only between frames.

module particle_cell #(
  parameter int WIDTH = 256,
  parameter int GRID  = 16
) (
  input  logic [15:0]               x,
  input  logic [15:0]               y,
  output logic [$clog2(GRID)-1:0]   col,
  output logic [$clog2(GRID)-1:0]   row
);
  localparam int WW = $clog2(WIDTH);
  localparam int CW = $clog2(GRID);

  logic [CW-1:0] cell_y;
  logic          unused_lo;
  assign unused_lo = ^{x, y};

  // Clamp to [0, WIDTH-1] and keep the top CW bits of the world coordinate.
  always_comb begin
    col    = '0;
    cell_y = '0;
    if (x[15])             col = '0;
    else if (|x[14:WW])    col = '1;
    else                   col = x[WW-1 -: CW];
    if (y[15])             cell_y = '0;
    else if (|y[14:WW])    cell_y = '1;
    else                   cell_y = y[WW-1 -: CW];
  end

  // +y is up: GRID-1-cell_y, which is the bitwise inverse for a power-of-2 grid.
  assign row = ~cell_y;
endmodule

module particle_plotter #(
  parameter int WIDTH        = 256,
  parameter int GRID         = 16,
  parameter int ROW_CYCLES   = 64,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             x0,
  input  logic [15:0]             y0,
  input  logic [15:0]             x1,
  input  logic [15:0]             y1,
  input  logic [15:0]             x2,
  input  logic [15:0]             y2,
  input  logic [15:0]             x3,
  input  logic [15:0]             y3,
  input  logic                    frame_tick,
  output logic [$clog2(GRID)-1:0] row_sel,
  output logic                    row_en,
  output logic [GRID-1:0]         col_data,
  output logic                    frame_done
);
  localparam int NP      = 4;
  localparam int CW      = $clog2(GRID);
  localparam int CNT_MAX = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {SWAP, LOAD, DISPLAY, BLANK} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    pending;
  logic [NP-1:0][15:0]     xs, ys;
  logic [NP-1:0][CW-1:0]   cap_col, cap_row;
  logic [NP-1:0][CW-1:0]   sh_col, sh_row, act_col, act_row;
  logic [NP-1:0]           sh_vld, act_vld;
  logic [GRID-1:0]         mask;

  assign xs = {x3, x2, x1, x0};
  assign ys = {y3, y2, y1, y0};

  particle_cell #(.WIDTH(WIDTH), .GRID(GRID)) u_cell [NP-1:0] (
    .x   (xs),
    .y   (ys),
    .col (cap_col),
    .row (cap_row)
  );

  // Coincident particles collapse to a single lit bit.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NP; i++)
      if (act_vld[i] && act_row[i] == row_sel) mask[act_col[i]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SWAP;
      cnt        <= '0;
      row_sel    <= '0;
      row_en     <= 1'b0;
      col_data   <= '0;
      frame_done <= 1'b0;
      pending    <= 1'b0;
      sh_vld     <= '0;
      act_vld    <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        SWAP: begin
          if (pending) begin
            act_col <= sh_col;
            act_row <= sh_row;
            act_vld <= sh_vld;
            pending <= 1'b0;
          end
          cnt   <= '0;
          state <= LOAD;
        end
        LOAD: begin
          col_data <= mask;
          row_en   <= 1'b1;
          cnt      <= '0;
          state    <= DISPLAY;
        end
        DISPLAY: begin
          if (cnt == CNT_W'(ROW_CYCLES - 1)) begin
            row_en   <= 1'b0;
            col_data <= '0;
            cnt      <= '0;
            state    <= BLANK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BLANK: begin
          if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
            cnt <= '0;
            if (row_sel == CW'(GRID - 1)) begin
              row_sel    <= '0;
              frame_done <= 1'b1;
              state      <= SWAP;
            end else begin
              row_sel <= row_sel + 1'b1;
              state   <= LOAD;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= SWAP;
      endcase
      // A capture coinciding with SWAP lands after the copy, so it stays pending.
      if (frame_tick) begin
        sh_col  <= cap_col;
        sh_row  <= cap_row;
        sh_vld  <= '1;
        pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_particle_plotter.sv
// Directed bench for particle_plotter: frame timing, clamping, cell mapping,
// tear-free promotion and reset behaviour, checked with immediate assertions.

module tb_particle_plotter;
  localparam int PERIOD = 1073;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] px[4], py[4], nx[4], ny[4];
  logic        frame_tick;
  logic [3:0]  row_sel;
  logic        row_en;
  logic [15:0] col_data;
  logic        frame_done;

  int          ncmp = 0;
  int          nfail = 0;
  logic [15:0] exp_img[16];
  logic [15:0] img[16];
  int          lit[16];
  int          inj_row;

  always #5 clk = ~clk;

  particle_plotter dut (
    .clk(clk), .reset(reset),
    .x0(px[0]), .y0(py[0]), .x1(px[1]), .y1(py[1]),
    .x2(px[2]), .y2(py[2]), .x3(px[3]), .y3(py[3]),
    .frame_tick(frame_tick), .row_sel(row_sel), .row_en(row_en),
    .col_data(col_data), .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pos(input int a0, b0, a1, b1, a2, b2, a3, b3);
    px[0] = 16'(a0); py[0] = 16'(b0); px[1] = 16'(a1); py[1] = 16'(b1);
    px[2] = 16'(a2); py[2] = 16'(b2); px[3] = 16'(a3); py[3] = 16'(b3);
  endtask

  task automatic set_nxt(input int a0, b0, a1, b1, a2, b2, a3, b3);
    nx[0] = 16'(a0); ny[0] = 16'(b0); nx[1] = 16'(a1); ny[1] = 16'(b1);
    nx[2] = 16'(a2); ny[2] = 16'(b2); nx[3] = 16'(a3); ny[3] = 16'(b3);
  endtask

  task automatic clear_exp;
    for (int r = 0; r < 16; r++) exp_img[r] = 16'h0;
  endtask

  // Tick until frame_done, counting cycles; optionally flag any lit row.
  task automatic wait_fd(input string tag, input int expect_n);
    int n, lit_bad;
    n = 0; lit_bad = 0;
    while (n < 1200) begin
      tick;
      n++;
      if (row_en && col_data != 16'h0) lit_bad++;
      if (frame_done) break;
    end
    check({tag, "_cycles"}, n, expect_n);
    check({tag, "_dark"}, lit_bad, 0);
  endtask

  // Observe one full frame starting in the SWAP cycle; ends on the next frame_done.
  task automatic scan_frame(input string tag);
    int unst, early;
    bit inj_done;
    unst = 0; early = 0; inj_done = 0;
    for (int r = 0; r < 16; r++) begin img[r] = 16'h0; lit[r] = 0; end
    for (int k = 1; k <= PERIOD; k++) begin
      if (inj_row >= 0 && !inj_done && row_en && int'(row_sel) == inj_row) begin
        px = nx; py = ny;
        frame_tick = 1'b1;
        inj_done = 1;
      end
      tick;
      frame_tick = 1'b0;
      if (k < PERIOD && frame_done) early++;
      if (row_en) begin
        if (lit[row_sel] == 0) img[row_sel] = col_data;
        else if (col_data != img[row_sel]) unst++;
        lit[row_sel]++;
      end
    end
    check({tag, "_fd_period"}, frame_done, 1'b1);
    check({tag, "_fd_early"}, early, 0);
    check({tag, "_stable"}, unst, 0);
    for (int r = 0; r < 16; r++) begin
      check($sformatf("%s_row%0d_cols", tag, r), img[r], exp_img[r]);
      check($sformatf("%s_row%0d_lit", tag, r), lit[r], 64);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    frame_tick = 1'b0;
    inj_row = -1;
    set_pos(0, 0, 0, 0, 0, 0, 0, 0);
    set_nxt(0, 0, 0, 0, 0, 0, 0, 0);
    tick; tick;
    check("rst_row_sel", row_sel, 4'd0);
    check("rst_row_en", row_en, 1'b0);
    check("rst_col_data", col_data, 16'h0);
    check("rst_frame_done", frame_done, 1'b0);
    reset = 1'b0;

    // Empty matrix: dark rows and a 1073-cycle frame period.
    wait_fd("first_fd", PERIOD);
    clear_exp;
    scan_frame("empty");

    // Image A: p0 mid-world, rest at origin.
    repeat (5) tick;
    set_pos(128, 128, 0, 0, 0, 0, 0, 0);
    frame_tick = 1'b1;
    tick;
    frame_tick = 1'b0;
    wait_fd("a_wait", PERIOD - 6);

    // Image B (clamping, corners, coincident pair) captured while row 5 is lit.
    set_nxt(40, 200, -5, 300, 255, 0, 40, 200);
    inj_row = 5;
    clear_exp;
    exp_img[7] = 16'h0100; exp_img[15] = 16'h0001;
    scan_frame("img_a");

    // Image C captured during row 10 so it is still pending at the next SWAP.
    set_nxt(100, 100, -1, -1, 300, -100, 17, 239);
    inj_row = 10;
    clear_exp;
    exp_img[0] = 16'h0001; exp_img[3] = 16'h0004; exp_img[15] = 16'h8000;
    scan_frame("img_b");

    // Image D arrives in the SWAP cycle itself: C shows first, D after.
    inj_row = -1;
    set_pos(240, 16, 32, 32, 32, 47, 15, 15);
    frame_tick = 1'b1;
    clear_exp;
    exp_img[1] = 16'h0002; exp_img[9] = 16'h0040; exp_img[15] = 16'h8001;
    scan_frame("img_c");
    clear_exp;
    exp_img[13] = 16'h0004; exp_img[14] = 16'h8000; exp_img[15] = 16'h0001;
    scan_frame("img_d");

    // Reset while row 9 is lit.
    n = 0;
    while (n < 1200 && !(row_en && row_sel == 4'd9)) begin tick; n++; end
    check("row9_found", (n < 1200), 1'b1);
    reset = 1'b1;
    tick;
    check("mid_rst_row_en", row_en, 1'b0);
    check("mid_rst_col_data", col_data, 16'h0);
    check("mid_rst_row_sel", row_sel, 4'd0);
    check("mid_rst_frame_done", frame_done, 1'b0);
    reset = 1'b0;
    wait_fd("post_rst", PERIOD);
    clear_exp;
    scan_frame("post_rst_dark");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/particle_plotter.md
Name: particle_plotter

Overview:
- Consumer side of the particle state outputs: snapshots the positions of the four mass-spring particles and drives a row-multiplexed 16x16 LED matrix.
- Positions are latched on a physics-frame strobe into a shadow buffer.
- The shadow buffer is promoted to the displayed image only at a display-frame boundary, so a frame never tears.

Parameters:
- WIDTH, 256, world size in position units per axis (power of 2, same as the particle world).
- GRID, 16, matrix rows/columns (power of 2, GRID <= WIDTH).
- ROW_CYCLES, 64, clocks each row is lit.
- BLANK_CYCLES, 2, dark clocks between rows (ghosting guard, >= 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- x0,y0,x1,y1,x2,y2,x3,y3  in  16 each  signed particle positions.
- frame_tick  in  1  one-cycle pulse: particle positions valid, capture them.
- row_sel  out  $clog2(GRID)  index of row being driven.
- row_en  out  1  row driver enable.
- col_data  out  GRID  column mask for row_sel; bit c = column c lit.
- frame_done  out  1  one-cycle pulse at end of each display frame.

Behaviour:
- Reset values: row_sel=0, row_en=0, col_data=0, frame_done=0; pending=0; all shadow and active valid bits = 0 (nothing lit); FSM goes to SWAP. Reset mid-operation gives the same result on the next edge.
- Capture, any state: on frame_tick, for each particle i:
  - clamp x and y to [0, WIDTH-1] (negative -> 0; >= WIDTH -> WIDTH-1).
  - cell = clamped >> log2(WIDTH/GRID).
  - shadow_i <= (col=cell_x, row=GRID-1-cell_y, valid=1); pending<=1.
  - +y is up, so row 0 is the top of the world.
- FSM states:
  - SWAP (1 cycle, entered only when row_sel==0): if pending, active<=shadow and pending<=0. If frame_tick occurs in the same cycle, SWAP copies the old shadow, the new capture is written to shadow, and pending stays 1 (capture wins). Next state LOAD.
  - LOAD (1 cycle): col_data <= OR over valid active particles whose row==row_sel of (1<<col); row_en=0. Next state DISPLAY.
  - DISPLAY (ROW_CYCLES cycles): row_en=1; col_data and row_sel stable. Next state BLANK.
  - BLANK (BLANK_CYCLES cycles): row_en=0, col_data=0.
    - On exit, if row_sel==GRID-1: row_sel<=0, pulse frame_done for 1 cycle (the first cycle of SWAP), go to SWAP.
    - Otherwise row_sel<=row_sel+1, go to LOAD.
- Internal cycle counter sized for max(ROW_CYCLES, BLANK_CYCLES); it restarts on every state entry.
- Frame period = GRID*(1+ROW_CYCLES+BLANK_CYCLES)+1 cycles; 1073 at defaults.
- Multiple particles in the same cell give a single bit (OR). Particles absent from a row contribute 0.
- row_en is never 1 while row_sel or col_data changes. Both update only in LOAD or BLANK.
- Outputs are registered; no combinational input-to-output paths.

Test Plan:
- Reset, then run 2000 cycles with no frame_tick -> col_data==0 whenever row_en==1; frame_done spacing exactly 1073 cycles.
- Particle0=(128,128), others=(0,0); frame_tick -> in the next frame:
  - row_sel=7 shows col_data=16'h0100 for 64 cycles.
  - row_sel=15 shows 16'h0001.
  - All other rows show 0.
- Particle1=(-5,300) -> clamped to (0,255) -> row_sel=0 shows col_data=16'h0001. Particle2=(255,0) -> row 15 col 15 -> 16'h8000 OR'd with other particles in row 15.
- Particles 0 and 3 both at (40,200) -> row 3 shows col_data=16'h0004 (single bit).
- frame_tick with new positions while row_sel=5 in DISPLAY -> rows 6..15 of the current frame still show the old image; the new image appears from row 0 after the next SWAP.
- frame_tick in the same cycle as SWAP with pending=1 -> the older snapshot is displayed this frame, the newer one next frame.
- Assert reset during DISPLAY of row 9 -> next cycle row_en=0, col_data=0, row_sel=0; the matrix stays dark until a frame_tick.
